coredma_cache_stream_ctrl: RTL and testbench

- Streaming FIFO controller for the DMA channel data cache (simple dual-port SRAM, one write port and one read port, registered read data).
- The upstream source-read engine pushes beats in through a valid/ready stream; the block writes them into the cache and prefetches them back out.
- It presents the data as a valid/ready stream to the downstream destination-write engine at one beat per cycle.
- It owns the cache pointers, occupancy count and read-latency hiding.

---
 rtl/coredma_cache_stream_ctrl_pkg.sv | 15 +
 rtl/coredma_cache_stream_ctrl_if.sv | 41 ++++
 rtl/coredma_cache_obuf.sv | 54 +++++
 rtl/coredma_cache_stream_ctrl.sv | 83 ++++++++
 tb/tb_coredma_cache_stream_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/coredma_cache_stream_ctrl_pkg.sv
// Shared constants and sizing helpers for the DMA channel cache stream controller.
// No logic; imported by the interface, the output buffer and the top.
package coredma_cache_stream_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int OBUF_DEPTH     = 2;
  localparam int OBUF_CNT_W     = $clog2(OBUF_DEPTH + 1);

  // COUNT must hold the full cache plus the in-flight read plus both output slots.
  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/coredma_cache_stream_ctrl_if.sv
// Bundles the upstream stream, the downstream stream, the cache SRAM port and the status flags.
// master = controller side, slave = surrounding engines and cache.
interface coredma_cache_stream_ctrl_if #(
  parameter int DATA_WIDTH = coredma_cache_stream_ctrl_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = coredma_cache_stream_ctrl_pkg::ADDR_WIDTH_DEF
);
  import coredma_cache_stream_ctrl_pkg::*;

  localparam int CW = count_width(ADDR_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_wen;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

  modport master (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data,
    output ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
    output count, empty, full
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data,
    input  ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
    input  count, empty, full
  );

endinterface

// File: rtl/coredma_cache_obuf.sv
// Two-entry output buffer fed by cache read responses; head drives the downstream stream.
// Push is written at the clock edge; pop frees the head the same edge; clear empties it.
module coredma_cache_obuf
  import coredma_cache_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OBUF_CNT_W-1:0] cnt,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  // slot0 is always the head; the read-issue throttle guarantees no push while already full
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) slot0 <= push_data;
          else           slot1 <= push_data;
          cnt <= cnt + OBUF_CNT_W'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - OBUF_CNT_W'(1);
        end
        2'b11: begin
          if (cnt == OBUF_CNT_W'(OBUF_DEPTH)) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (cnt != '0);
  assign head_data  = slot0;

endmodule

// File: rtl/coredma_cache_stream_ctrl.sv
// Streams beats through the channel data cache: write on accept, prefetch into a 2-entry buffer.
// First-word latency 3 cycles, 1 beat/cycle steady state; reads throttle on obuf space, writes on cache space.
module coredma_cache_stream_ctrl
  import coredma_cache_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic                      clock,
  input logic                      reset,
  input logic                      flush,
  coredma_cache_stream_ctrl_if.master io
);

  localparam int                  CW    = count_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  clr;
  logic                  wr;
  logic                  rd;
  logic                  pop;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [OBUF_CNT_W-1:0] obuf_cnt;
  logic                  obuf_vld;
  logic [DATA_WIDTH-1:0] obuf_head;
  logic [2:0]            pending;

  assign clr = reset | flush;

  assign io.in_ready = !clr && (ram_cnt != DEPTH);
  assign wr          = io.in_valid && io.in_ready;

  assign io.out_valid = !clr && obuf_vld;
  assign io.out_data  = clr ? '0 : obuf_head;
  assign pop          = io.out_valid && io.out_ready;

  // Issue only if the response is guaranteed an obuf slot; ram_cnt is registered so a
  // slot written this cycle cannot be read until the next one.
  assign pending = 3'(obuf_cnt) + 3'(inflight);
  assign rd      = !clr && (ram_cnt != '0) && (pending < (3'(OBUF_DEPTH) + 3'(pop)));

  assign io.ram_wen   = wr;
  assign io.ram_waddr = clr ? '0 : wr_ptr;
  assign io.ram_wdata = io.in_data;
  assign io.ram_ren   = rd;
  assign io.ram_raddr = clr ? '0 : rd_ptr;

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_cnt  <= ram_cnt + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(rd);
      inflight <= rd;
    end
  end

  // A response landing during clear is dropped; inflight is already zero the cycle after.
  coredma_cache_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clock      (clock),
    .clear      (clr),
    .push       (inflight),
    .push_data  (io.ram_rdata),
    .pop        (pop),
    .cnt        (obuf_cnt),
    .head_valid (obuf_vld),
    .head_data  (obuf_head)
  );

  assign io.count = CW'(ram_cnt) + CW'(inflight) + CW'(obuf_cnt);
  assign io.empty = (io.count == '0);
  assign io.full  = (ram_cnt == DEPTH);

endmodule

// File: tb/tb_coredma_cache_stream_ctrl.sv
// Bench for coredma_cache_stream_ctrl: behavioural SRAM, queue scoreboard, directed and random phases.
module tb_coredma_cache_stream_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  coredma_cache_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  coredma_cache_stream_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  always #5 clock = ~clock;

  // Simple dual-port cache with registered read data
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int accs   = 0;
  int pops   = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called with inputs settled; records handshakes, advances one clock, ends at the next negedge.
  task automatic step();
    logic acc_now;
    logic pop_now;
    logic [DW-1:0] exp;
    acc_now = bus.in_valid && bus.in_ready;
    pop_now = bus.out_valid && bus.out_ready;
    check("ram_rw_same_addr", DW'(bus.ram_wen && bus.ram_ren && (bus.ram_waddr == bus.ram_raddr)), 0);
    if (pop_now) begin
      pops++;
      check("pop_nonempty", DW'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("out_data_order", bus.out_data, exp);
      end
    end
    if (acc_now) begin
      accs++;
      sb.push_back(bus.in_data);
    end
    @(posedge clock);
    if (reset || flush) sb.delete();
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_out_valid"}, DW'(bus.out_valid), 0);
    check({pfx, "_out_data"},  bus.out_data, 0);
    check({pfx, "_count"},     DW'(bus.count), 0);
    check({pfx, "_empty"},     DW'(bus.empty), 1);
    check({pfx, "_full"},      DW'(bus.full), 0);
    check({pfx, "_ram_wen"},   DW'(bus.ram_wen), 0);
    check({pfx, "_ram_ren"},   DW'(bus.ram_ren), 0);
    check({pfx, "_ram_waddr"}, DW'(bus.ram_waddr), 0);
    check({pfx, "_ram_raddr"}, DW'(bus.ram_raddr), 0);
    check({pfx, "_in_ready"},  DW'(bus.in_ready), 1);
  endtask

  initial begin
    int a0;
    int p0;
    int n;
    int in_pct;
    int out_pct;

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    in_pct  = 50;
    out_pct = 50;

    // Reset
    @(negedge clock);
    bus.in_valid = 1'b1;
    #1;
    check("rst_in_ready", DW'(bus.in_ready), 0);
    check("rst_ram_wen", DW'(bus.ram_wen), 0);
    check("rst_out_valid", DW'(bus.out_valid), 0);
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_reset_values("post_rst");
    step();

    // Single beat latency
    bus.in_valid = 1'b1; bus.in_data = DW'('hA5); bus.out_ready = 1'b1;
    #1;
    check("c0_ram_wen", DW'(bus.ram_wen), 1);
    check("c0_ram_waddr", DW'(bus.ram_waddr), 0);
    check("c0_ram_wdata", bus.ram_wdata, DW'('hA5));
    step();
    bus.in_valid = 1'b0;
    #1;
    check("c1_ram_ren", DW'(bus.ram_ren), 1);
    check("c1_ram_raddr", DW'(bus.ram_raddr), 0);
    check("c1_out_valid", DW'(bus.out_valid), 0);
    step(); #1;
    check("c2_out_valid", DW'(bus.out_valid), 0);
    check("c2_count", DW'(bus.count), 1);
    step(); #1;
    check("c3_out_valid", DW'(bus.out_valid), 1);
    check("c3_out_data", bus.out_data, DW'('hA5));
    step(); #1;
    check("c4_count", DW'(bus.count), 0);
    check("c4_empty", DW'(bus.empty), 1);
    check("c4_out_valid", DW'(bus.out_valid), 0);
    step();

    // Streaming 300 beats, pointers wrap twice
    a0 = accs; p0 = pops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i + 1000);
      #1; step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; step();
    end
    check("stream_accepted", DW'(accs - a0), 300);
    check("stream_popped", DW'(pops - p0), 300);
    check("stream_drained", DW'(sb.size()), 0);

    // Fill to capacity with downstream stalled
    a0 = accs; p0 = pops; n = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = rnd();
    #1;
    while (bus.in_ready && n < 400) begin
      step();
      n++;
      bus.in_data = rnd();
      #1;
    end
    check("full_accepted", DW'(accs - a0), 130);
    check("full_flag", DW'(bus.full), 1);
    check("full_count", DW'(bus.count), 130);
    check("full_in_ready", DW'(bus.in_ready), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("release_same_cycle", DW'(bus.in_ready), 0);
    step(); #1;
    check("release_next_cycle", DW'(bus.in_ready), 1);
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      step(); n++; #1;
    end
    check("full_drained", DW'(sb.size()), 0);
    check("full_popped", DW'(pops - p0), 130);
    step();

    // Random traffic with shifting pressure
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) begin
        in_pct  = $urandom_range(10, 100);
        out_pct = $urandom_range(10, 100);
      end
      check("rand_count", DW'(bus.count), DW'(sb.size()));
      check("rand_empty", DW'(bus.empty), DW'(sb.size() == 0));
      bus.in_valid  = ($urandom_range(1, 100) <= in_pct);
      bus.in_data   = rnd();
      bus.out_ready = ($urandom_range(1, 100) <= out_pct);
      #1; step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    #1;
    while (sb.size() != 0 && n < 400) begin
      step(); n++; #1;
    end
    check("rand_drained", DW'(sb.size()), 0);
    step();

    // Flush with a read in flight
    p0 = pops;
    bus.in_valid = 1'b1; bus.in_data = DW'('h1234); bus.out_ready = 1'b1;
    #1; step();
    bus.in_valid = 1'b0;
    #1;
    check("fl_ren", DW'(bus.ram_ren), 1);
    step();
    flush = 1'b1;
    #1;
    check("fl_wen", DW'(bus.ram_wen), 0);
    check("fl_ren_during", DW'(bus.ram_ren), 0);
    check("fl_in_ready", DW'(bus.in_ready), 0);
    check("fl_out_valid", DW'(bus.out_valid), 0);
    step();
    flush = 1'b0;
    #1;
    check("fl_post_out_valid", DW'(bus.out_valid), 0);
    check("fl_post_count", DW'(bus.count), 0);
    check("fl_post_empty", DW'(bus.empty), 1);
    bus.in_valid = 1'b1; bus.in_data = DW'('h5678);
    #1;
    check("fl_next_wen", DW'(bus.ram_wen), 1);
    check("fl_next_waddr", DW'(bus.ram_waddr), 0);
    step();
    bus.in_valid = 1'b0;
    #1;
    check("fl_next_raddr", DW'(bus.ram_raddr), 0);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
    end
    check("fl_single_pop", DW'(pops - p0), 1);
    check("fl_drained", DW'(sb.size()), 0);
    step();

    // Reset with 50 beats held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.in_data = rnd();
      #1; step();
    end
    #1;
    check("mid_count", DW'(bus.count), 50);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", DW'(bus.in_ready), 0);
    check("mid_rst_wen", DW'(bus.ram_wen), 0);
    check("mid_rst_ren", DW'(bus.ram_ren), 0);
    check("mid_rst_out_valid", DW'(bus.out_valid), 0);
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_reset_values("mid_post_rst");
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
